// File: rtl/mem_bus_master.sv
// MEM-stage initiator: turns load/store strobes into ready/valid data-memory requests and stalls the pipeline.
// Optional watchdog (sticky bus_err, 32'hDEADBEEF read data) is built when MEM_TIMEOUT_EN is defined.
module mem_bus_master #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       val_rm,
  output logic              freeze,
  output logic [31:0]       res_data,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_data,
  output logic              bus_err
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] rd_q;
  logic [31:0] off_c;
  logic        access_c;
  logic        busy_c;
  logic        tmo_c;
  logic        tmo_fire_c;
  logic        unused_c;

  assign access_c = mem_r_en | mem_w_en;
  assign busy_c   = (state == S_REQ) | (state == S_WAIT_RSP);
  assign off_c    = alu_res - BASE_ADDR;
  assign unused_c = ^{off_c[31:ADDR_W+2], off_c[1:0], 32'(TIMEOUT_CYC)};

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wdog;
  logic            err_q;

  // Limit reached in the TIMEOUT_CYC-th busy cycle; a handshake or response that same cycle wins.
  assign tmo_c      = busy_c & (wdog == WD_W'(TIMEOUT_CYC - 1));
  assign tmo_fire_c = tmo_c & ~((state == S_REQ) & bus_req_ready)
                            & ~((state == S_WAIT_RSP) & bus_rsp_valid);
  assign bus_err    = err_q;

  // Held at zero in IDLE so every access starts counting from its first REQ cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        wdog <= '0;
      end else if (busy_c) begin
        wdog <= wdog + WD_W'(1);
      end
      if (tmo_fire_c) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_c      = 1'b0;
  assign tmo_fire_c = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (access_c) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus_req_ready) begin
          state_nxt = bus_req_we ? S_DONE : S_WAIT_RSP;
        end else if (tmo_c) begin
          state_nxt = S_DONE;
        end
      end
      S_WAIT_RSP: begin
        if (bus_rsp_valid | tmo_c) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request payload is captured once in IDLE and held until the access completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      rd_q          <= '0;
    end else begin
      if ((state == S_IDLE) && access_c) begin
        bus_req_we    <= mem_w_en;
        bus_req_addr  <= off_c[ADDR_W+1:2];
        bus_req_wdata <= val_rm;
      end
      if ((state == S_WAIT_RSP) && bus_rsp_valid) begin
        rd_q <= bus_rsp_data;
      end else if (tmo_fire_c && !bus_req_we) begin
        rd_q <= 32'hDEAD_BEEF;
      end
    end
  end

  assign bus_req_valid = (state == S_REQ);
  assign freeze        = rst & (((state == S_IDLE) & access_c) | busy_c);
  assign res_data      = mem_r_en ? rd_q : 32'h0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized bench for mem_bus_master: a transaction-level timeline model drives per-cycle expectations.
module tb_mem_bus_master;
  localparam int unsigned ADDR_W = 11;
  localparam logic [31:0] BASE   = 32'd1024;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_r_en, mem_w_en;
  logic [31:0]       alu_res, val_rm;
  logic              freeze;
  logic [31:0]       res_data;
  logic              bus_req_valid, bus_req_ready, bus_req_we;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [31:0]       bus_req_wdata;
  logic              bus_rsp_valid;
  logic [31:0]       bus_rsp_data;
  logic              bus_err;

  mem_bus_master #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .freeze(freeze), .res_data(res_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic              chk_en = 1'b0;
  logic              exp_freeze, exp_valid, exp_we, exp_err;
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       exp_wdata, exp_res, last_rd;

  int                hs_cnt, fz_cnt;
  logic [ADDR_W-1:0] obs_addr;
  logic              obs_we, done_freeze;
  logic [31:0]       obs_wdata, done_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Byte address -> word address: remove segment base, divide by word size, wrap to bus width.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return ADDR_W'((off / 4) % (32'd1 << ADDR_W));
  endfunction

  always @(negedge clk) begin
    if (bus_req_valid === 1'b1 && bus_req_ready === 1'b1) begin
      hs_cnt++;
      obs_addr  = bus_req_addr;
      obs_we    = bus_req_we;
      obs_wdata = bus_req_wdata;
    end
    if (freeze === 1'b1) fz_cnt++;
    if (chk_en) begin
      check("freeze", 32'(freeze), 32'(exp_freeze));
      check("req_valid", 32'(bus_req_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("req_addr", 32'(bus_req_addr), 32'(exp_addr));
        check("req_we", 32'(bus_req_we), 32'(exp_we));
        check("req_wdata", bus_req_wdata, exp_wdata);
      end
      check("res_data", res_data, exp_res);
      check("bus_err", 32'(bus_err), 32'(exp_err));
    end
  end

  // One pipeline access: ready after dr stall cycles, read response ds cycles after the first WAIT cycle.
  task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int dr, input int ds, input int gap);
    int rsp_k, done_k;
    rsp_k  = dr + 2 + ds;
    done_k = w ? dr + 2 : rsp_k + 1;
    hs_cnt = 0;
    fz_cnt = 0;
    for (int k = 0; k <= done_k; k++) begin
      @(posedge clk); #1;
      mem_r_en = r;
      mem_w_en = w;
      alu_res  = (k == 0) ? a : $urandom;
      val_rm   = (k == 0) ? wd : $urandom;
      bus_req_ready = (k == dr + 1) ? 1'b1 : ((k == 0 || k > dr + 1) ? 1'($urandom) : 1'b0);
      bus_rsp_data  = $urandom;
      if (!w && k == rsp_k) begin
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = rd;
      end else if (k == 0 || (k >= 1 && k <= dr) || k == done_k) begin
        bus_rsp_valid = 1'($urandom);
      end else begin
        bus_rsp_valid = 1'b0;
      end
      exp_freeze = (k < done_k);
      exp_valid  = (k >= 1 && k <= dr + 1);
      exp_addr   = word_addr(a);
      exp_we     = w;
      exp_wdata  = wd;
      exp_res    = r ? ((!w && k > rsp_k) ? rd : last_rd) : 32'h0;
      chk_en     = 1'b1;
      if (k == done_k) begin
        @(negedge clk);
        done_res    = res_data;
        done_freeze = freeze;
      end
    end
    if (!w) last_rd = rd;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      mem_r_en      = 1'b0;
      mem_w_en      = 1'b0;
      alu_res       = $urandom;
      bus_req_ready = 1'($urandom);
      bus_rsp_valid = 1'($urandom);
      bus_rsp_data  = $urandom;
      exp_freeze    = 1'b0;
      exp_valid     = 1'b0;
      exp_res       = 32'h0;
    end
  endtask

  initial begin
    rst = 1'b0;
    mem_r_en = 1'b1; mem_w_en = 1'b0; alu_res = 32'd1032; val_rm = 32'h0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'h0;
    last_rd = 32'h0; exp_err = 1'b0;
    #2;
    check("rst_valid", 32'(bus_req_valid), 32'h0);
    check("rst_freeze", 32'(freeze), 32'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_addr", 32'(bus_req_addr), 32'h0);
    check("rst_we", 32'(bus_req_we), 32'h0);
    check("rst_wdata", bus_req_wdata, 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    repeat (2) @(posedge clk);
    #1 mem_r_en = 1'b0; rst = 1'b1;

    // Store with ready already high: one request, two freeze cycles.
    xact(1'b0, 1'b1, 32'd1028, 32'h0000_CAFE, 32'h0, 0, 0, 1);
    check("t2_handshakes", 32'(hs_cnt), 32'd1);
    check("t2_addr", 32'(obs_addr), 32'd1);
    check("t2_we", 32'(obs_we), 32'd1);
    check("t2_wdata", obs_wdata, 32'h0000_CAFE);
    check("t2_freeze_cycles", 32'(fz_cnt), 32'd2);
    check("t2_done_freeze", 32'(done_freeze), 32'h0);

    // Load stalled 3 cycles, response 2 cycles after acceptance.
    xact(1'b1, 1'b0, 32'd1032, 32'h0, 32'h0000_1234, 3, 1, 1);
    check("t3_addr", 32'(obs_addr), 32'd2);
    check("t3_we", 32'(obs_we), 32'd0);
    check("t3_res_data", done_res, 32'h0000_1234);
    check("t3_done_freeze", 32'(done_freeze), 32'h0);
    check("t3_freeze_cycles", 32'(fz_cnt), 32'd7);
    check("t3_handshakes", 32'(hs_cnt), 32'd1);

    // Reset in the middle of a stalled read request.
    chk_en = 1'b0;
    @(posedge clk); #1 mem_r_en = 1'b1; alu_res = 32'd1036; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_pre_valid", 32'(bus_req_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("t1_valid", 32'(bus_req_valid), 32'h0);
    check("t1_freeze", 32'(freeze), 32'h0);
    check("t1_res_data", res_data, 32'h0);
    @(posedge clk); #1 mem_r_en = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 32'hBAD0_0BAD;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t1_idle_valid", 32'(bus_req_valid), 32'h0);
    check("t1_idle_freeze", 32'(freeze), 32'h0);
    last_rd = 32'h0;

    // Both strobes high resolve to a single write.
    xact(1'b1, 1'b1, 32'd1024, 32'h55AA_0F0F, 32'h0, 0, 0, 1);
    check("t4_handshakes", 32'(hs_cnt), 32'd1);
    check("t4_addr", 32'(obs_addr), 32'd0);
    check("t4_we", 32'(obs_we), 32'd1);
    check("t4_wdata", obs_wdata, 32'h55AA_0F0F);

    // Address below the segment base wraps.
    xact(1'b1, 1'b0, 32'd0, 32'h0, 32'hA5A5_0001, 1, 0, 0);
    check("t5_addr", 32'(obs_addr), 32'd1792);
    check("t5_res_data", done_res, 32'hA5A5_0001);

    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 2);
      a   = ($urandom_range(0, 3) == 0) ? $urandom : BASE + 32'($urandom_range(0, 8191));
      xact(sel != 1, sel != 0, a, $urandom, $urandom, $urandom_range(0, 2),
           $urandom_range(0, 2), $urandom_range(0, 2));
    end

`ifdef MEM_TIMEOUT_EN
    // Read that never gets a response: watchdog ends it after TMO busy cycles.
    chk_en = 1'b0;
    @(posedge clk); #1 mem_r_en = 1'b1; mem_w_en = 1'b0; alu_res = 32'd1040;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    @(posedge clk); #1 bus_req_ready = 1'b1;
    @(posedge clk); #1 bus_req_ready = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t6_last_wait_freeze", 32'(freeze), 32'h1);
    @(negedge clk);
    check("t6_done_freeze", 32'(freeze), 32'h0);
    check("t6_valid", 32'(bus_req_valid), 32'h0);
    check("t6_res_data", res_data, 32'hDEAD_BEEF);
    check("t6_err", 32'(bus_err), 32'h1);
    last_rd = 32'hDEAD_BEEF;
    exp_err = 1'b1;
    xact(1'b0, 1'b1, 32'd1100, 32'h0000_0077, 32'h0, 1, 0, 1);
    xact(1'b1, 1'b0, 32'd1104, 32'h0, 32'h0000_0099, 0, 1, 1);
    check("t6_err_sticky", 32'(bus_err), 32'h1);
`endif

    @(posedge clk); #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
